// File: rtl/xbar_output_arbiter.sv
// Read-side scheduler for one crossbar output port: round-robin grant over N_IN
// FIFOs with bounded bursts, feeding a registered valid/ready output stage.
module xbar_output_arbiter #(
  parameter int N_IN      = 4,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                     clk_rx,
  input  logic                     nrst_rx,
  input  logic [N_IN-1:0]          fifo_empty,
  input  logic [N_IN*DATA_W-1:0]   fifo_rdata,
  output logic [N_IN-1:0]          fifo_pop,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  input  logic                     out_ready,
  output logic [$clog2(N_IN)-1:0]  grant_id,
  output logic                     busy
);
  // Output handshake: a word transfers on any clock edge where out_valid and
  // out_ready are both high; out_valid/out_data hold steady until that happens.

  localparam int GW = $clog2(N_IN);
  localparam int BW = $clog2(MAX_BURST) + 1;
  localparam logic [GW:0]   N_IN_W    = (GW+1)'(N_IN);
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [GW-1:0]     grant_id_q, grant_id_d;
  logic [GW-1:0]     last_grant_q, last_grant_d;
  logic [BW-1:0]     burst_cnt_q, burst_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  logic [DATA_W-1:0] rdata_arr [N_IN];
  logic [GW-1:0]     winner;
  logic              found;
  logic [GW:0]       cand_sum;
  logic              pop_fire;

  for (genvar gi = 0; gi < N_IN; gi++) begin : g_slice
    assign rdata_arr[gi] = fifo_rdata[gi*DATA_W +: DATA_W];
  end

  // First non-empty index after last_grant, wrapping modulo N_IN.
  always_comb begin
    winner   = '0;
    found    = 1'b0;
    cand_sum = '0;
    for (int i = 0; i < N_IN; i++) begin
      cand_sum = {1'b0, last_grant_q} + (GW+1)'(i + 1);
      if (cand_sum >= N_IN_W) cand_sum = cand_sum - N_IN_W;
      if (!found && !fifo_empty[cand_sum[GW-1:0]]) begin
        winner = cand_sum[GW-1:0];
        found  = 1'b1;
      end
    end
  end

  assign pop_fire = (state_q == GRANT) && !fifo_empty[grant_id_q] &&
                    (!out_valid_q || out_ready);

  always_comb begin
    fifo_pop = '0;
    if (pop_fire) fifo_pop[grant_id_q] = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    burst_cnt_d  = burst_cnt_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;

    if (pop_fire) begin
      out_data_d  = rdata_arr[grant_id_q];
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (found) begin
          grant_id_d  = winner;
          burst_cnt_d = '0;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        // An empty granted FIFO is trusted as truly empty and gives up the port.
        if (fifo_empty[grant_id_q]) begin
          state_d      = IDLE;
          last_grant_d = grant_id_q;
        end else if (pop_fire) begin
          burst_cnt_d = burst_cnt_q + BW'(1);
          if (burst_cnt_q == LAST_BEAT) begin
            state_d      = IDLE;
            last_grant_d = grant_id_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_rx or negedge nrst_rx) begin
    if (!nrst_rx) begin
      state_q      <= IDLE;
      grant_id_q   <= '0;
      last_grant_q <= GW'(N_IN - 1);
      burst_cnt_q  <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      burst_cnt_q  <= burst_cnt_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign grant_id  = grant_id_q;
  assign busy      = (state_q == GRANT);

endmodule

// File: tb/tb_xbar_output_arbiter.sv
// Bench for xbar_output_arbiter: FIFOs modelled as queues, directed scenarios
// plus a randomized run against a transaction-level scheduler model.
module tb_xbar_output_arbiter;
  localparam int N_IN      = 4;
  localparam int DATA_W    = 32;
  localparam int MAX_BURST = 4;
  localparam int GW        = $clog2(N_IN);

  logic                    clk_rx = 1'b0;
  logic                    nrst_rx;
  logic [N_IN-1:0]         fifo_empty;
  logic [N_IN*DATA_W-1:0]  fifo_rdata;
  logic [N_IN-1:0]         fifo_pop;
  logic                    out_valid;
  logic [DATA_W-1:0]       out_data;
  logic                    out_ready;
  logic [GW-1:0]           grant_id;
  logic                    busy;

  int checks   = 0;
  int failures = 0;

  // clock / reset block
  always #5 clk_rx = ~clk_rx;

  xbar_output_arbiter #(.N_IN(N_IN), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
    .clk_rx    (clk_rx),
    .nrst_rx   (nrst_rx),
    .fifo_empty(fifo_empty),
    .fifo_rdata(fifo_rdata),
    .fifo_pop  (fifo_pop),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  logic [DATA_W-1:0] fq [N_IN][$];

  // observed DUT values for the cycle just stepped
  logic [N_IN-1:0]   obs_pop;
  logic              obs_valid, obs_acc, obs_busy;
  logic [DATA_W-1:0] obs_data;
  logic [GW-1:0]     obs_gid;

  // scheduler model: owner<0 means no grant; exp_q is the pending output word
  int                m_owner, m_last, m_gid, m_cnt;
  logic [DATA_W-1:0] exp_q[$];
  logic [N_IN-1:0]   m_exp_pop;
  logic              m_exp_valid, m_exp_busy;
  logic [DATA_W-1:0] m_exp_data;
  int                m_exp_gid;

  task automatic model_reset();
    m_owner = -1;
    m_last  = N_IN - 1;
    m_gid   = 0;
    m_cnt   = 0;
    exp_q.delete();
  endtask

  task automatic drive();
    for (int i = 0; i < N_IN; i++) begin
      fifo_empty[i] = (fq[i].size() == 0);
      fifo_rdata[i*DATA_W +: DATA_W] = (fq[i].size() > 0) ? fq[i][0] : '0;
    end
  endtask

  // One clock: observe at negedge, update model and FIFO queues at posedge.
  task automatic tick();
    logic popping;
    int   cand;
    @(negedge clk_rx);
    obs_pop   = fifo_pop;
    obs_valid = out_valid;
    obs_data  = out_data;
    obs_gid   = grant_id;
    obs_busy  = busy;
    obs_acc   = out_valid & out_ready;
    m_exp_pop = '0;
    if (m_owner >= 0 && fq[m_owner].size() > 0 && (exp_q.size() == 0 || out_ready))
      m_exp_pop[m_owner] = 1'b1;
    m_exp_valid = (exp_q.size() > 0);
    m_exp_data  = m_exp_valid ? exp_q[0] : '0;
    m_exp_busy  = (m_owner >= 0);
    m_exp_gid   = m_gid;
    popping     = (m_exp_pop != '0);
    @(posedge clk_rx);
    if (nrst_rx) begin
      if (m_exp_valid && out_ready) void'(exp_q.pop_front());
      if (popping) exp_q.push_back(fq[m_owner][0]);
      if (m_owner < 0) begin
        for (int k = 1; k <= N_IN; k++) begin
          cand = (m_last + k) % N_IN;
          if (m_owner < 0 && fq[cand].size() > 0) begin
            m_owner = cand;
            m_gid   = cand;
            m_cnt   = 0;
          end
        end
      end else if (fq[m_owner].size() == 0) begin
        m_last  = m_owner;
        m_owner = -1;
      end else if (popping) begin
        m_cnt++;
        if (m_cnt == MAX_BURST) begin
          m_last  = m_owner;
          m_owner = -1;
        end
      end
      for (int i = 0; i < N_IN; i++)
        if (obs_pop[i] && fq[i].size() > 0) void'(fq[i].pop_front());
    end
    #1;
    drive();
  endtask

  task automatic apply_reset();
    nrst_rx   = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < N_IN; i++) fq[i].delete();
    drive();
    model_reset();
    repeat (2) @(posedge clk_rx);
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
    checks++;
    if (out_data !== '0) begin failures++; $display("FAIL rst_data got=%h exp=0", out_data); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++;
    if (fifo_pop !== '0) begin failures++; $display("FAIL rst_pop got=%b exp=0", fifo_pop); end
    checks++;
    if (grant_id !== '0) begin failures++; $display("FAIL rst_gid got=%0d exp=0", grant_id); end
    nrst_rx = 1'b1;
  endtask

  task automatic test_single_source();
    logic [DATA_W-1:0] words[3];
    logic [DATA_W-1:0] got[$];
    int pop_ticks[$];
    int first_valid = -1;
    for (int i = 0; i < 3; i++) begin
      words[i] = DATA_W'($urandom());
      fq[0].push_back(words[i]);
    end
    out_ready = 1'b1;
    drive();
    for (int t = 0; t < 8; t++) begin
      tick();
      if (obs_pop != '0) begin
        pop_ticks.push_back(t);
        checks++;
        if (obs_pop !== 4'b0001) begin failures++; $display("FAIL ss_pop_vec t=%0d got=%b exp=0001", t, obs_pop); end
      end
      if (obs_valid && first_valid < 0) first_valid = t;
      if (obs_acc) got.push_back(obs_data);
    end
    checks++;
    if (pop_ticks.size() != 3 || pop_ticks[0] != 1 || pop_ticks[2] != 3)
      begin failures++; $display("FAIL ss_pop_cycles got_n=%0d exp_n=3 (cycles 1..3)", pop_ticks.size()); end
    checks++;
    if (first_valid != 2) begin failures++; $display("FAIL ss_latency got=%0d exp=2", first_valid); end
    checks++;
    if (got.size() != 3 || got[0] !== words[0] || got[1] !== words[1] || got[2] !== words[2])
      begin failures++; $display("FAIL ss_data got_n=%0d exp_n=3", got.size()); end
    checks++;
    if (obs_gid !== 2'd0 || obs_busy !== 1'b0)
      begin failures++; $display("FAIL ss_release got=gid%0d/busy%b exp=gid0/busy0", obs_gid, obs_busy); end
  endtask

  task automatic test_contention();
    logic [DATA_W-1:0] exp_words[32];
    logic [DATA_W-1:0] got[$];
    int glog[$];
    int pcount[8];
    int idle_between = 0;
    logic prev_busy = 1'b0;
    apply_reset();
    nrst_rx = 1'b1;
    for (int g = 0; g < N_IN; g++)
      for (int j = 0; j < 8; j++) begin
        logic [DATA_W-1:0] w;
        w = DATA_W'($urandom());
        fq[g].push_back(w);
        exp_words[(j / 4) * 16 + g * 4 + (j % 4)] = w;
      end
    for (int i = 0; i < 8; i++) pcount[i] = 0;
    drive();
    for (int t = 0; t < 55; t++) begin
      tick();
      if (obs_busy && !prev_busy) glog.push_back(int'(obs_gid));
      if (!obs_busy && glog.size() > 0 && glog.size() < 8) idle_between++;
      if (obs_pop != '0 && glog.size() > 0 && glog.size() <= 8) pcount[glog.size()-1]++;
      if (obs_acc) got.push_back(obs_data);
      prev_busy = obs_busy;
    end
    checks++;
    if (glog.size() != 8) begin failures++; $display("FAIL ct_grants got=%0d exp=8", glog.size()); end
    for (int i = 0; i < 8 && i < glog.size(); i++) begin
      checks++;
      if (glog[i] != i % 4) begin failures++; $display("FAIL ct_order idx=%0d got=%0d exp=%0d", i, glog[i], i % 4); end
      checks++;
      if (pcount[i] != MAX_BURST) begin failures++; $display("FAIL ct_burst idx=%0d got=%0d exp=%0d", i, pcount[i], MAX_BURST); end
    end
    checks++;
    if (idle_between != 7) begin failures++; $display("FAIL ct_idle got=%0d exp=7", idle_between); end
    checks++;
    if (got.size() != 32) begin failures++; $display("FAIL ct_count got=%0d exp=32", got.size()); end
    for (int i = 0; i < 32 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_words[i]) begin failures++; $display("FAIL ct_data idx=%0d got=%h exp=%h", i, got[i], exp_words[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] w0, w1;
    w0 = DATA_W'($urandom());
    w1 = DATA_W'($urandom());
    fq[1].push_back(w0);
    fq[1].push_back(w1);
    out_ready = 1'b1;
    drive();
    tick();
    tick();
    checks++;
    if (obs_pop !== 4'b0010) begin failures++; $display("FAIL bp_first_pop got=%b exp=0010", obs_pop); end
    out_ready = 1'b0;
    for (int t = 0; t < 5; t++) begin
      tick();
      checks++;
      if (obs_valid !== 1'b1 || obs_data !== w0)
        begin failures++; $display("FAIL bp_hold t=%0d got=%b/%h exp=1/%h", t, obs_valid, obs_data, w0); end
      checks++;
      if (obs_pop !== '0 || obs_busy !== 1'b1)
        begin failures++; $display("FAIL bp_stall t=%0d got=pop%b/busy%b exp=pop0000/busy1", t, obs_pop, obs_busy); end
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (obs_acc !== 1'b1 || obs_data !== w0 || obs_pop !== 4'b0010)
      begin failures++; $display("FAIL bp_accept got=%b/%h/%b exp=1/%h/0010", obs_acc, obs_data, obs_pop, w0); end
    tick();
    checks++;
    if (obs_acc !== 1'b1 || obs_data !== w1)
      begin failures++; $display("FAIL bp_second got=%b/%h exp=1/%h", obs_acc, obs_data, w1); end
    repeat (3) tick();
  endtask

  task automatic test_rr_pointer();
    int glog[$];
    logic prev_busy = 1'b0;
    fq[2].push_back(DATA_W'($urandom()));
    drive();
    repeat (5) tick();
    fq[0].push_back(DATA_W'($urandom()));
    fq[3].push_back(DATA_W'($urandom()));
    drive();
    for (int t = 0; t < 12; t++) begin
      tick();
      if (obs_busy && !prev_busy) glog.push_back(int'(obs_gid));
      prev_busy = obs_busy;
    end
    checks++;
    if (glog.size() != 2 || glog[0] != 3 || glog[1] != 0)
      begin failures++; $display("FAIL rr_order got_n=%0d first=%0d exp=3 then 0", glog.size(), (glog.size() > 0) ? glog[0] : -1); end
  endtask

  task automatic test_empty_lag();
    logic [DATA_W-1:0] w[3];
    logic [DATA_W-1:0] got[$];
    int glog[$];
    int first_pops = 0;
    logic prev_busy = 1'b0;
    for (int i = 0; i < 3; i++) w[i] = DATA_W'($urandom());
    fq[2].push_back(w[0]);
    drive();
    for (int t = 0; t < 16; t++) begin
      tick();
      if (obs_busy && !prev_busy) glog.push_back(int'(obs_gid));
      if (obs_pop != '0 && glog.size() == 1) first_pops++;
      if (obs_acc) got.push_back(obs_data);
      if (t == 3) begin
        checks++;
        if (obs_busy !== 1'b0) begin failures++; $display("FAIL el_release got=%b exp=0", obs_busy); end
        fq[2].push_back(w[1]);
        fq[2].push_back(w[2]);
        drive();
      end
      prev_busy = obs_busy;
    end
    checks++;
    if (first_pops != 1) begin failures++; $display("FAIL el_first_burst got=%0d exp=1", first_pops); end
    checks++;
    if (glog.size() != 2 || glog[0] != 2 || glog[1] != 2)
      begin failures++; $display("FAIL el_regrant got_n=%0d exp=2 grants of fifo 2", glog.size()); end
    checks++;
    if (got.size() != 3 || got[0] !== w[0] || got[1] !== w[1] || got[2] !== w[2])
      begin failures++; $display("FAIL el_data got_n=%0d exp_n=3", got.size()); end
  endtask

  task automatic test_reset_mid_burst();
    int glog[$];
    logic prev_busy = 1'b0;
    fq[2].push_back(DATA_W'($urandom()));
    drive();
    repeat (5) tick();
    for (int i = 0; i < 4; i++) fq[1].push_back(DATA_W'($urandom()));
    drive();
    tick();
    tick();
    checks++;
    if (fifo_pop !== 4'b0010) begin failures++; $display("FAIL rm_second_pop got=%b exp=0010", fifo_pop); end
    #2;
    nrst_rx = 1'b0;
    model_reset();
    #1;
    checks++;
    if (fifo_pop !== '0 || out_valid !== 1'b0 || busy !== 1'b0 || grant_id !== '0 || out_data !== '0)
      begin failures++; $display("FAIL rm_async got=pop%b/v%b/b%b/g%0d/d%h exp=all zero", fifo_pop, out_valid, busy, grant_id, out_data); end
    repeat (2) tick();
    nrst_rx = 1'b1;
    checks++;
    if (fq[1].size() != 3) begin failures++; $display("FAIL rm_fifo_kept got=%0d exp=3", fq[1].size()); end
    fq[0].push_back(DATA_W'($urandom()));
    fq[3].push_back(DATA_W'($urandom()));
    drive();
    for (int t = 0; t < 30; t++) begin
      tick();
      if (obs_busy && !prev_busy) glog.push_back(int'(obs_gid));
      prev_busy = obs_busy;
    end
    checks++;
    if (glog.size() != 3 || glog[0] != 0 || glog[1] != 1 || glog[2] != 3)
      begin failures++; $display("FAIL rm_restart got_n=%0d first=%0d exp=0,1,3", glog.size(), (glog.size() > 0) ? glog[0] : -1); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 500; t++) begin
      if (t < 440) begin
        if ($urandom_range(0, 2) == 0) begin
          int f;
          f = $urandom_range(0, N_IN - 1);
          if (fq[f].size() < 6) fq[f].push_back(DATA_W'($urandom()));
        end
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        out_ready = 1'b1;
      end
      drive();
      tick();
      checks++;
      if (obs_pop !== m_exp_pop) begin failures++; $display("FAIL rnd_pop t=%0d got=%b exp=%b", t, obs_pop, m_exp_pop); end
      checks++;
      if (obs_valid !== m_exp_valid) begin failures++; $display("FAIL rnd_valid t=%0d got=%b exp=%b", t, obs_valid, m_exp_valid); end
      if (m_exp_valid) begin
        checks++;
        if (obs_data !== m_exp_data) begin failures++; $display("FAIL rnd_data t=%0d got=%h exp=%h", t, obs_data, m_exp_data); end
      end
      checks++;
      if (obs_busy !== m_exp_busy) begin failures++; $display("FAIL rnd_busy t=%0d got=%b exp=%b", t, obs_busy, m_exp_busy); end
      checks++;
      if (int'(obs_gid) != m_exp_gid) begin failures++; $display("FAIL rnd_gid t=%0d got=%0d exp=%0d", t, obs_gid, m_exp_gid); end
    end
  endtask

  initial begin
    nrst_rx    = 1'b0;
    out_ready  = 1'b1;
    fifo_empty = '1;
    fifo_rdata = '0;
    model_reset();
    test_reset();
    test_single_source();
    test_contention();
    test_backpressure();
    test_rr_pointer();
    test_empty_lag();
    test_reset_mid_burst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
